// File: rtl/q_link_pkg.sv
// Shared definitions for the serialized-charge link: defaults common to the
// transmitter and the receiving pulse counter, and the transmitter state encoding.
package q_link_pkg;

    localparam int DEF_BUS_WIDTH   = 10;
    localparam int DEF_Q_PER_PULSE = 30;
    localparam int WTD_BUS_WIDTH   = 2;
    // Receiver watchdog depth plus two cycles of margin.
    localparam int GAP_MIN         = 2**WTD_BUS_WIDTH + 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DIVIDE   = 3'd1,
        ST_PULSE_HI = 3'd2,
        ST_PULSE_LO = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } q_tx_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/q_const_divider.sv
// Iterative divide-by-constant: one subtraction per cycle after load.
// valid is high in the cycle the remainder has dropped below the divisor.
module q_const_divider #(
    parameter int WIDTH   = 10,
    parameter int DIVISOR = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam logic [WIDTH-1:0] DIV_W = WIDTH'(DIVISOR);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        busy_d = busy_q;
        if (load) begin
            rem_d  = dividend;
            quo_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (rem_q >= DIV_W) begin
                rem_d = rem_q - DIV_W;
                quo_d = quo_q + WIDTH'(1);
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    assign busy      = busy_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign valid     = busy_q && (rem_q < DIV_W);

endmodule

// File: rtl/q_pulse_serializer.sv
// Transmit side of the serialized-charge link: charge word -> pulse burst + quiet gap.
// state     | meaning
// IDLE      | waiting for start
// DIVIDE    | divider running, one subtraction per cycle
// PULSE_HI  | line high, HIGH_CYCLES
// PULSE_LO  | line low, LOW_CYCLES, pulse retired at the end
// GAP       | line low, GAP_CYCLES, lets the receiver watchdog latch
// DONE      | one-cycle done strobe
module q_pulse_serializer
    import q_link_pkg::*;
#(
    parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int Q_PER_PULSE = DEF_Q_PER_PULSE,
    parameter int HIGH_CYCLES = 1,
    parameter int LOW_CYCLES  = 1,
    parameter int GAP_CYCLES  = GAP_MIN + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [BUS_WIDTH-1:0] q_in,
    output logic                 q_serialized,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] pulse_count,
    output logic [BUS_WIDTH-1:0] q_residual
);

    localparam int TW = $clog2(max3(HIGH_CYCLES, LOW_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TW-1:0] HI_LD  = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] LO_LD  = TW'(LOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);

    q_tx_state_t          state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BUS_WIDTH-1:0] left_q, left_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic [BUS_WIDTH-1:0] res_q, res_d;
    logic                 q_ser_q, q_ser_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 div_load;
    logic                 div_busy;
    logic                 div_valid;
    logic [BUS_WIDTH-1:0] div_quo;
    logic [BUS_WIDTH-1:0] div_rem;

    q_const_divider #(
        .WIDTH   (BUS_WIDTH),
        .DIVISOR (Q_PER_PULSE)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .dividend  (q_in),
        .busy      (div_busy),
        .quotient  (div_quo),
        .remainder (div_rem),
        .valid     (div_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            left_q  <= '0;
            pc_q    <= '0;
            res_q   <= '0;
            q_ser_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            left_q  <= left_d;
            pc_q    <= pc_d;
            res_q   <= res_d;
            q_ser_q <= q_ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        left_d   = left_q;
        pc_d     = pc_q;
        res_d    = res_q;
        div_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_DIVIDE;
                    div_load = 1'b1;
                end
            end
            ST_DIVIDE: begin
                if (abort) begin
                    state_d = ST_GAP;
                    pc_d    = '0;
                end else if (div_busy && div_valid) begin
                    pc_d    = div_quo;
                    res_d   = div_rem;
                    left_d  = div_quo;
                    state_d = (div_quo != '0) ? ST_PULSE_HI : ST_GAP;
                end
            end
            ST_PULSE_HI: begin
                // The pulse in flight has not completed its high phase yet.
                if (abort) begin
                    state_d = ST_GAP;
                    pc_d    = pc_q - left_q;
                end else if (timer_q == '0) begin
                    state_d = ST_PULSE_LO;
                end
            end
            ST_PULSE_LO: begin
                if (abort) begin
                    state_d = ST_GAP;
                    pc_d    = pc_q - left_q + BUS_WIDTH'(1);
                end else if (timer_q == '0) begin
                    left_d  = left_q - BUS_WIDTH'(1);
                    state_d = (left_q == BUS_WIDTH'(1)) ? ST_GAP : ST_PULSE_HI;
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            case (state_d)
                ST_PULSE_HI: timer_d = HI_LD;
                ST_PULSE_LO: timer_d = LO_LD;
                ST_GAP:      timer_d = GAP_LD;
                default:     timer_d = '0;
            endcase
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end
    end

    // Outputs are decoded from the next state so they land in flops aligned with state_q.
    always_comb begin
        q_ser_d = (state_d == ST_PULSE_HI);
        busy_d  = !((state_d == ST_IDLE) || (state_d == ST_DONE));
        done_d  = (state_d == ST_DONE);
    end

    assign q_serialized = q_ser_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pulse_count  = pc_q;
    assign q_residual   = res_q;

endmodule

// File: tb/tb_q_pulse_serializer.sv
// Bench for q_pulse_serializer: timeline model of the burst checked every cycle,
// plus literal expectations for the directed cases.
module tb_q_pulse_serializer;

    localparam int BW  = 10;
    localparam int QPP = 30;
    localparam int H   = 1;
    localparam int L   = 1;
    localparam int G   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [BW-1:0] q_in;
    logic          q_serialized;
    logic          busy;
    logic          done;
    logic [BW-1:0] pulse_count;
    logic [BW-1:0] q_residual;

    q_pulse_serializer #(
        .BUS_WIDTH   (BW),
        .Q_PER_PULSE (QPP),
        .HIGH_CYCLES (H),
        .LOW_CYCLES  (L),
        .GAP_CYCLES  (G)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .q_in         (q_in),
        .q_serialized (q_serialized),
        .busy         (busy),
        .done         (done),
        .pulse_count  (pulse_count),
        .q_residual   (q_residual)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int start_ref = 0;
    int cur_c = 0;
    bit active = 1'b0;
    int txn_seen = 0;
    int pulses_seen = 0;
    int done_at = -1;
    bit prev_ser = 1'b0;
    int m_q = 0;
    int m_abort = -1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s (c=%0d): got %0d expected %0d", nm, cur_c, act, exp);
        end
    endtask

    // Model: cycle c counts from the start cycle (c=0); outputs after the accepting edge are c=1.
    function automatic int m_n();
        return m_q / QPP;
    endfunction

    function automatic int pulse_start(input int i);
        return m_n() + 2 + i * (H + L);
    endfunction

    function automatic int exp_t();
        if (m_abort < 0) return 1 + (m_n() + 1) + m_n() * (H + L) + G;
        return m_abort + G + 1;
    endfunction

    function automatic int exp_ser(input int c);
        for (int i = 0; i < m_n(); i++) begin
            if (c >= pulse_start(i) && c < pulse_start(i) + H &&
                (m_abort < 0 || c <= m_abort)) return 1;
        end
        return 0;
    endfunction

    function automatic int exp_pc();
        int n;
        if (m_abort < 0) return m_n();
        n = 0;
        for (int i = 0; i < m_n(); i++) begin
            if (pulse_start(i) + H - 1 < m_abort) n++;
        end
        return n;
    endfunction

    function automatic bit res_known();
        return (m_abort < 0) || (m_abort >= m_n() + 2);
    endfunction

    // Compare process
    initial begin
        forever begin
            @(posedge clk);
            ncyc++;
            #1;
            if (active && !rst) begin
                cur_c = ncyc - start_ref;
                if (cur_c == 1) begin
                    pulses_seen = 0;
                    done_at = -1;
                    prev_ser = 1'b0;
                end
                chk("q_serialized", int'(q_serialized), exp_ser(cur_c));
                chk("busy", int'(busy), (cur_c >= 1 && cur_c < exp_t()) ? 1 : 0);
                chk("done", int'(done), (cur_c == exp_t()) ? 1 : 0);
                if (q_serialized && !prev_ser) pulses_seen++;
                prev_ser = q_serialized;
                if (done) done_at = cur_c;
                if (m_abort < 0 && m_n() > 0 && cur_c == m_n() + 2)
                    chk("pulse_count_entry", int'(pulse_count), m_n());
                if (cur_c >= exp_t()) begin
                    chk("pulse_count", int'(pulse_count), exp_pc());
                    if (res_known()) chk("q_residual", int'(q_residual), m_q % QPP);
                end
                if (cur_c == exp_t() + 1) txn_seen++;
            end
        end
    end

    task automatic run_txn(input int q, input int ab, input int rs);
        int seen0;
        bit fin;
        @(negedge clk);
        m_q = q;
        m_abort = ab;
        q_in = BW'(q);
        start = 1'b1;
        start_ref = ncyc;
        seen0 = txn_seen;
        active = 1'b1;
        fin = 1'b0;
        for (int k = 1; k < 2000 && !fin; k++) begin
            @(negedge clk);
            start = (k == rs);
            abort = (k == ab);
            q_in = BW'($urandom);
            if (txn_seen != seen0) fin = 1'b1;
        end
        if (!fin) chk("txn_timeout", 0, 1);
        start = 1'b0;
        abort = 1'b0;
        active = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        q_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_q_serialized", int'(q_serialized), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pulse_count", int'(pulse_count), 0);
        chk("rst_q_residual", int'(q_residual), 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(90, -1, -1);
        chk("t1_done_at", done_at, 19);
        chk("t1_pulses", pulses_seen, 3);
        chk("t1_pulse_count", int'(pulse_count), 3);
        chk("t1_q_residual", int'(q_residual), 0);

        run_txn(100, -1, -1);
        chk("t2_loopback_charge", pulses_seen * QPP, 90);
        chk("t2_q_residual", int'(q_residual), 10);

        run_txn(0, -1, -1);
        chk("t3a_pulses", pulses_seen, 0);
        chk("t3a_done_at", done_at, 10);
        chk("t3a_q_residual", int'(q_residual), 0);

        run_txn(29, -1, -1);
        chk("t3b_pulses", pulses_seen, 0);
        chk("t3b_pulse_count", int'(pulse_count), 0);
        chk("t3b_q_residual", int'(q_residual), 29);

        run_txn(1023, -1, 40);
        chk("t4_pulses", pulses_seen, 34);
        chk("t4_pulse_count", int'(pulse_count), 34);
        chk("t4_q_residual", int'(q_residual), 3);

        run_txn(300, 18, -1);
        chk("t5_pulse_count", int'(pulse_count), 3);
        chk("t5_done_at", done_at, 27);
        chk("t5_rising_edges", pulses_seen, 4);

        run_txn(300, 3, -1);
        chk("t5b_pulse_count", int'(pulse_count), 0);
        chk("t5b_done_at", done_at, 12);

        // Start held during DONE must not launch a new burst.
        run_txn(30, -1, 13);
        chk("done_start_done_at", done_at, 13);
        @(negedge clk);
        chk("done_start_busy", int'(busy), 0);

        // Abort has priority over start in IDLE.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        q_in = BW'(90);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);
        @(negedge clk);
        chk("idle_abort_busy2", int'(busy), 0);

        // Reset in the middle of the first high phase.
        @(negedge clk);
        m_q = 90;
        m_abort = -1;
        q_in = BW'(90);
        start = 1'b1;
        start_ref = ncyc;
        active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_pre_rst_high", int'(q_serialized), 1);
        active = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_q_serialized", int'(q_serialized), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_pulse_count", int'(pulse_count), 0);
        chk("t6_rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(60, -1, -1);
        chk("t6_pulses", pulses_seen, 2);
        chk("t6_pulse_count", int'(pulse_count), 2);
        chk("t6_q_residual", int'(q_residual), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
